// File: rtl/opb_select_if.sv
// Operand-B select stage bus: request side from decode, result side to the ALU.
interface opb_select_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               in_sel;
  logic [4:0]               in_rs2_addr;
  logic [XLEN-1:0]          in_rs2_data;
  logic [11:0]              in_imm_i;
  logic [11:0]              in_imm_s;
  logic [19:0]              in_imm_u;
  logic [XLEN-1:0]          in_pc;
  logic [NUM_FWD-1:0]       fwd_valid;
  logic [5*NUM_FWD-1:0]     fwd_addr;
  logic [XLEN*NUM_FWD-1:0]  fwd_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_opb;
  logic                     out_fwd;
  logic                     out_err;
  logic [15:0]              stat_fwd_cnt;

  modport slave (
    input  in_valid, in_sel, in_rs2_addr, in_rs2_data, in_imm_i, in_imm_s,
           in_imm_u, in_pc, fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_opb, out_fwd, out_err, stat_fwd_cnt
  );
  modport master (
    output in_valid, in_sel, in_rs2_addr, in_rs2_data, in_imm_i, in_imm_s,
           in_imm_u, in_pc, fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_opb, out_fwd, out_err, stat_fwd_cnt
  );
endinterface

// File: rtl/opb_select_stage.sv
// Registered ALU operand-B select with immediate extension, rs2 forwarding and
// a main register backed by a one-entry skid buffer.
module opb_select_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  opb_select_if.slave   bus
);
  typedef struct packed {
    logic [XLEN-1:0] opb;
    logic            fwd;
    logic            err;
  } ent_t;

  ent_t            new_ent, main_q, main_d, skid_q, skid_d;
  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] fwd_opb;
  logic            fwd_hit, accept, drain;

  // Descending scan so the lowest matching source wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_opb = bus.in_rs2_data;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (bus.fwd_valid[k] && bus.fwd_addr[5*k +: 5] == bus.in_rs2_addr) begin
        fwd_hit = 1'b1;
        fwd_opb = bus.fwd_data[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    new_ent = '0;
    case (bus.in_sel)
      3'd0: if (bus.in_rs2_addr != 5'd0) begin
              new_ent.opb = fwd_opb;
              new_ent.fwd = fwd_hit;
            end
      3'd1: new_ent.opb = {{(XLEN-11){bus.in_imm_i[11]}}, bus.in_imm_i[10:0]};
      3'd2: new_ent.opb = {{(XLEN-11){bus.in_imm_s[11]}}, bus.in_imm_s[10:0]};
      3'd3: new_ent.opb = bus.in_pc;
      3'd4: new_ent.opb = {{(XLEN-31){bus.in_imm_u[19]}}, bus.in_imm_u[18:0], 12'b0};
      3'd5: new_ent.opb = {{(XLEN-3){1'b0}}, 3'd4};
      default: new_ent.err = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && rdy_q;
  assign drain  = main_vld_q && bus.out_ready;

  // in_ready is low whenever skid is full, so accept never coincides with a
  // skid-to-main move.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (drain) begin
        main_vld_d = skid_vld_q;
        skid_vld_d = 1'b0;
        if (skid_vld_q) main_d = skid_q;
      end
      if (accept) begin
        if (!main_vld_q || drain) begin
          main_vld_d = 1'b1;
          main_d     = new_ent;
        end else begin
          skid_vld_d = 1'b1;
          skid_d     = new_ent;
        end
        if (new_ent.fwd && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.out_valid    = main_vld_q;
  assign bus.out_opb      = main_q.opb;
  assign bus.out_fwd      = main_q.fwd;
  assign bus.out_err      = main_q.err;
  assign bus.stat_fwd_cnt = cnt_q;
endmodule

// File: tb/tb_opb_select_stage.sv
// Bench for opb_select_stage: directed scenarios plus randomized traffic against
// a queue-based reference model of a two-deep FIFO.
module tb_opb_select_stage;
  logic clk, rst_n;
  int total = 0, bad = 0;

  opb_select_if #(.XLEN(32), .NUM_FWD(2)) bus();
  opb_select_if #(.XLEN(64), .NUM_FWD(1)) bus64();

  opb_select_stage #(.XLEN(32), .NUM_FWD(2)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  opb_select_stage #(.XLEN(64), .NUM_FWD(1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opb;
    logic        fwd;
    logic        err;
  } exp_t;

  exp_t    q[$];
  logic    rdy_m;
  int      cnt_m;

  function automatic exp_t model_op();
    exp_t e;
    int   v;
    e.opb = 0; e.fwd = 0; e.err = 0;
    case (bus.in_sel)
      0: if (bus.in_rs2_addr != 0) begin
           e.opb = bus.in_rs2_data;
           for (int k = 0; k < 2; k++)
             if (bus.fwd_valid[k] && bus.fwd_addr[k*5 +: 5] == bus.in_rs2_addr) begin
               e.opb = bus.fwd_data[k*32 +: 32];
               e.fwd = 1;
               break;
             end
         end
      1: begin v = int'(bus.in_imm_i); if (v >= 2048) v -= 4096; e.opb = v; end
      2: begin v = int'(bus.in_imm_s); if (v >= 2048) v -= 4096; e.opb = v; end
      3: e.opb = bus.in_pc;
      4: e.opb = 32'(bus.in_imm_u) * 4096;
      5: e.opb = 4;
      default: e.err = 1;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    rdy_m = 1;
    cnt_m = 0;
  endtask

  task automatic tick();
    exp_t e;
    bit   acc;
    @(posedge clk);
    e   = model_op();
    acc = bus.in_valid && rdy_m;
    if (bus.flush) q.delete();
    else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.fwd && cnt_m < 65535) cnt_m++;
      end
    end
    rdy_m = (q.size() < 2);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_sel = 0; bus.in_rs2_addr = 0; bus.in_rs2_data = 0;
    bus.in_imm_i = 0; bus.in_imm_s = 0; bus.in_imm_u = 0; bus.in_pc = 0;
    bus.fwd_valid = 0; bus.fwd_addr = 0; bus.fwd_data = 0; bus.flush = 0;
    bus.out_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    bus64.in_valid = 0; bus64.in_sel = 0; bus64.in_rs2_addr = 0; bus64.in_rs2_data = 0;
    bus64.in_imm_i = 0; bus64.in_imm_s = 0; bus64.in_imm_u = 0; bus64.in_pc = 0;
    bus64.fwd_valid = 0; bus64.fwd_addr = 0; bus64.fwd_data = 0; bus64.flush = 0;
    bus64.out_ready = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_opb !== 32'h0) begin bad++; $display("FAIL reset_opb got=%h exp=0", bus.out_opb); end
    total++; if ({bus.out_fwd, bus.out_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.out_fwd, bus.out_err}); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.stat_fwd_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", bus.stat_fwd_cnt); end
  endtask

  task automatic test_imm();
    logic [2:0]  sel[5]  = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    logic [31:0] want[5] = '{32'hFFFF_F800, 32'h0000_07FF, 32'h8000_0000, 32'h4, 32'h1234_5678};
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.in_valid = 1; bus.in_sel = sel[i];
      bus.in_imm_i = 12'h800; bus.in_imm_s = 12'h7FF; bus.in_imm_u = 20'h80000; bus.in_pc = 32'h1234_5678;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_opb !== want[i] || bus.out_err !== 1'b0) begin
        bad++; $display("FAIL imm_sel%0d got=%b/%h exp=1/%h", sel[i], bus.out_valid, bus.out_opb, want[i]);
      end
    end
    idle();
    bus64.in_valid = 1; bus64.in_sel = 3'd4; bus64.in_imm_u = 20'h80000;
    tick();
    total++; if (bus64.out_opb !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL imm_u64 got=%h exp=ffffffff80000000", bus64.out_opb); end
    bus64.in_sel = 3'd1; bus64.in_imm_i = 12'h800;
    tick();
    total++; if (bus64.out_opb !== 64'hFFFF_FFFF_FFFF_F800) begin bad++; $display("FAIL imm_i64 got=%h exp=fffffffffffff800", bus64.out_opb); end
    bus64.in_valid = 0;
    tick();
  endtask

  task automatic test_fwd_priority();
    logic [31:0] a = 32'hAAAA_0001, b = 32'hBBBB_0002;
    idle();
    bus.in_valid = 1; bus.in_sel = 0; bus.in_rs2_addr = 5; bus.in_rs2_data = 32'hDEAD_BEEF;
    bus.fwd_valid = 2'b11; bus.fwd_addr = {5'd5, 5'd5}; bus.fwd_data = {b, a};
    tick();
    total++; if (bus.out_opb !== a || bus.out_fwd !== 1'b1) begin bad++; $display("FAIL fwd_prio got=%h/%b exp=%h/1", bus.out_opb, bus.out_fwd, a); end
    total++; if (bus.stat_fwd_cnt !== 16'd1) begin bad++; $display("FAIL fwd_cnt got=%0d exp=1", bus.stat_fwd_cnt); end
    bus.in_rs2_addr = 0;
    tick();
    total++; if (bus.out_opb !== 32'h0 || bus.out_fwd !== 1'b0) begin bad++; $display("FAIL fwd_x0 got=%h/%b exp=0/0", bus.out_opb, bus.out_fwd); end
    total++; if (bus.stat_fwd_cnt !== 16'd1) begin bad++; $display("FAIL fwd_x0_cnt got=%0d exp=1", bus.stat_fwd_cnt); end
    idle();
    tick();
  endtask

  task automatic test_reserved();
    for (int s = 6; s < 8; s++) begin
      idle();
      bus.in_valid = 1; bus.in_sel = 3'(s); bus.in_rs2_addr = 3; bus.in_rs2_data = 32'hFFFF_FFFF;
      tick();
      total++; if (bus.out_opb !== 32'h0 || bus.out_err !== 1'b1) begin bad++; $display("FAIL reserved_%0d got=%h/%b exp=0/1", s, bus.out_opb, bus.out_err); end
    end
    idle();
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] x = $urandom, y = $urandom, z = $urandom;
    idle();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_rs2_addr = 1;
    bus.in_rs2_data = x; tick();
    bus.in_rs2_data = y; tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", bus.in_ready); end
    bus.in_rs2_data = z; tick();
    total++; if (bus.out_opb !== x || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h exp=%h", bus.out_opb, x); end
    bus.in_valid = 0; bus.out_ready = 1; tick();
    total++; if (bus.out_opb !== y || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h exp=%h", bus.out_opb, y); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_recover got=%b exp=1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_z got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int c0;
    for (int n = 1; n <= 2; n++) begin
      idle();
      bus.out_ready = 0; bus.in_valid = 1; bus.in_sel = 5;
      repeat (n) tick();
      c0 = cnt_m;
      bus.flush = 1; bus.in_sel = 0; bus.in_rs2_addr = 9;
      bus.fwd_valid = 2'b01; bus.fwd_addr = {5'd0, 5'd9}; bus.fwd_data = {32'h0, 32'h5151_5151};
      tick();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush%0d_state got=%b/%b exp=0/1", n, bus.out_valid, bus.in_ready); end
      total++; if (bus.stat_fwd_cnt !== 16'(c0)) begin bad++; $display("FAIL flush%0d_cnt got=%0d exp=%0d", n, bus.stat_fwd_cnt, c0); end
      idle();
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush%0d_drop got=%b exp=0", n, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_sel      = 3'($urandom_range(0, 7));
      bus.in_rs2_addr = 5'($urandom_range(0, 7));
      bus.in_rs2_data = $urandom;
      bus.in_imm_i    = 12'($urandom); bus.in_imm_s = 12'($urandom); bus.in_imm_u = 20'($urandom);
      bus.in_pc       = $urandom;
      bus.fwd_valid   = 2'($urandom);
      bus.fwd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fwd_data    = {32'($urandom), 32'($urandom)};
      bus.flush       = ($urandom_range(0, 31) == 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (bus.out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, q.size() != 0); end
      total++; if (bus.in_ready !== rdy_m) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, rdy_m); end
      total++; if (bus.stat_fwd_cnt !== 16'(cnt_m)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, bus.stat_fwd_cnt, cnt_m); end
      if (q.size() != 0) begin
        total++;
        if (bus.out_opb !== q[0].opb || bus.out_fwd !== q[0].fwd || bus.out_err !== q[0].err) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h/%b/%b exp=%h/%b/%b", i, bus.out_opb, bus.out_fwd, bus.out_err, q[0].opb, q[0].fwd, q[0].err);
        end
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_saturation();
    idle();
    bus.in_valid = 1; bus.in_sel = 0; bus.in_rs2_addr = 3;
    bus.fwd_valid = 2'b01; bus.fwd_addr = {5'd0, 5'd3}; bus.fwd_data = {32'h0, 32'h0000_0033};
    repeat (65600) tick();
    total++; if (bus.stat_fwd_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h exp=ffff", bus.stat_fwd_cnt); end
    total++; if (bus.out_opb !== 32'h33 || bus.out_fwd !== 1'b1) begin bad++; $display("FAIL sat_data got=%h/%b exp=33/1", bus.out_opb, bus.out_fwd); end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_sel = 2; bus.in_imm_s = 12'hFFF;
    tick(); tick();
    bus.in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_opb !== 32'h0) begin bad++; $display("FAIL areset_out got=%b/%h exp=0/0", bus.out_valid, bus.out_opb); end
    total++; if (bus.in_ready !== 1'b1 || bus.stat_fwd_cnt !== 16'h0) begin bad++; $display("FAIL areset_ctl got=%b/%h exp=1/0", bus.in_ready, bus.stat_fwd_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    bus.out_ready = 1;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL areset_after got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_fwd_priority();
    test_reserved();
    test_back_pressure();
    test_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
